// File: rtl/ram_bytewrite_initiator.sv
// Byte-write RAM initiator: core load/store requests to word address, lane enables, load extract.
// Optional build macro RAM_DOUT_REG_EN adds a WAIT state for RAMs with a registered read port.
module ram_bytewrite_initiator #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]           ram_din_q, ram_din_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;

    logic [3:0]  lane_we;
    logic [31:0] lane_din;
    logic        req_err;
    logic [31:0] shifted;
    logic [31:0] ext;

    // Address bits above the RAM window are intentionally dropped (wrap).
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    // Decode the incoming request into lane enables, replicated data and error.
    always_comb begin
        lane_we  = 4'b0000;
        lane_din = req_wdata;
        req_err  = 1'b0;
        unique case (req_size)
            2'd0: begin
                lane_we  = 4'b0001 << req_addr[1:0];
                lane_din = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_err  = req_addr[0];
                lane_we  = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_din = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                req_err  = |req_addr[1:0];
                lane_we  = 4'b1111;
                lane_din = req_wdata;
            end
            default: begin
                req_err = 1'b1;
            end
        endcase
        if (req_err || !req_we) begin
            lane_we = 4'b0000;
        end
    end

    // Next-state logic; request attributes are captured on the accept cycle.
    always_comb begin
        state_d    = state_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        off_d      = off_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        we_d       = we_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d    = ISSUE;
                    ram_addr_d = req_addr[ADDR_WIDTH+1:2];
                    ram_din_d  = lane_din;
                    ram_we_d   = lane_we;
                    off_d      = req_addr[1:0];
                    size_d     = req_size;
                    sgn_d      = req_signed;
                    we_d       = req_we;
                    err_d      = req_err;
                end
            end
            ISSUE: begin
                ram_we_d = 4'b0000;
`ifdef RAM_DOUT_REG_EN
                state_d  = WAIT;
`else
                state_d  = RESP;
`endif
            end
`ifdef RAM_DOUT_REG_EN
            WAIT: begin
                state_d = RESP;
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                ram_we_d = 4'b0000;
            end
        endcase
    end

    // State and captured-request registers; reset also aborts an in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ram_we_q   <= 4'b0000;
            ram_addr_q <= '0;
            ram_din_q  <= 32'd0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            sgn_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            off_q      <= off_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            we_q       <= we_d;
            err_q      <= err_d;
        end
    end

    // Align the addressed lane to bit 0 and extend it per the captured size/sign.
    always_comb begin
        shifted = ram_dout >> {off_q, 3'b000};
        unique case (size_q)
            2'd0:    ext = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ext = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ext : 32'd0;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

endmodule

// File: doc/ram_bytewrite_initiator.md
Name: ram_bytewrite_initiator

Overview:
Initiator side of the single-port byte-write RAM interface used for code/data memory. It accepts load/store requests from the core (byte/half/word, signed/unsigned) and converts them to a word address, 4-bit byte-lane write enables and replicated write data. On loads it extracts and extends the addressed lane from the RAM's read data. It sits between the nanorv32 load/store path and a 32-bit RAM with per-byte write enables.

Parameters:
ADDR_WIDTH, 12, RAM word-address width; request byte address bits [ADDR_WIDTH+1:2] drive ram_addr.

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  one-cycle response pulse; no back-pressure
rsp_rdata  output  32  load result; 0 for stores and errors
rsp_err  output  1  misaligned or illegal-size request; valid with rsp_valid
ram_we  output  4  byte-lane write enables, bit i = bits [8i+7:8i]
ram_addr  output  ADDR_WIDTH  RAM word address
ram_din  output  32  RAM write data
ram_dout  input  32  RAM read data; read-first, one-cycle latency

Behaviour:
- Reset (async, immediate): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, ram_we=0, ram_addr=0, ram_din=0.
- FSM: IDLE -> ISSUE -> RESP -> IDLE. req_ready=1 only in IDLE. Each transaction takes 3 cycles.
- Accept cycle N (IDLE, req_valid=1):
  - Register ram_addr=req_addr[ADDR_WIDTH+1:2]; higher address bits are ignored, so addresses wrap.
  - Register ram_din and ram_we per the lane rules below.
  - Register latched addr[1:0], size, signed, we and err.
- ISSUE (cycle N+1): RAM outputs are valid. RAM samples at the end of N+1.
- RESP (cycle N+2):
  - rsp_valid=1. ram_we returns to 0 from cycle N+2; ram_addr holds its last value.
  - rsp_rdata is formed combinationally from ram_dout and is valid only while rsp_valid=1.
  - Stores respond with rsp_rdata=0.
- Lane rules, a = req_addr[1:0]:
  - Byte: ram_we=4'b0001<<a; ram_din = req_wdata[7:0] replicated 4 times.
  - Half: ram_we=4'b0011 (a=0) or 4'b1100 (a=2); ram_din = req_wdata[15:0] replicated 2 times.
  - Word: ram_we=4'b1111; ram_din=req_wdata.
- Load extraction: shift ram_dout right by 8*a, take 8/16/32 bits, then sign- or zero-extend per the latched signed bit. Word loads ignore the signed bit.
- Error: half with a[0]=1, word with a!=0, or size=3.
  - No RAM write: ram_we stays 0 during ISSUE.
  - Same latency as a normal transaction; rsp_err=1 and rsp_rdata=0 in RESP.
- req_valid while not IDLE: ignored, not accepted. The requester holds its request until the handshake.
- Reset asserted during ISSUE: ram_we drops to 0 immediately, the write is aborted and no response is issued.

Optional Feature:
RAM_DOUT_REG_EN:
- Defined: targets a RAM with a registered output (two-cycle read latency). A WAIT state is inserted, giving IDLE -> ISSUE -> WAIT -> RESP. rsp_valid moves to N+3 for all requests, including stores and errors, to keep latency uniform. ram_we=0 in WAIT.
- Undefined: no WAIT state; response at N+2 as above.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF -> ram_we=4'b1111 and ram_addr=4 in N+1, rsp_valid in N+2. Load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte stores to 0x20..0x23 with data 0x11,0x22,0x33,0x84 -> ram_we = 0001, 0010, 0100, 1000. Word load 0x20 -> 0x84332211. Signed byte load 0x23 -> 0xFFFFFF84; unsigned -> 0x00000084.
- Half: store 0xABCD at 0x32 -> ram_we=4'b1100, ram_din=0xABCDABCD. Signed half load 0x32 -> 0xFFFFABCD; unsigned -> 0x0000ABCD.
- Misaligned: word store at 0x41 -> ram_we stays 0, rsp_err=1, rsp_rdata=0 at N+2; RAM content unchanged on readback. Also size=3 -> rsp_err=1.
- Back-to-back: req_valid held high for 2 requests -> req_ready low in ISSUE and RESP; second accepted at N+3; no request lost or duplicated.
- Reset in ISSUE of a word store to 0x50 -> ram_we=0 asynchronously, no rsp_valid; subsequent load 0x50 returns the old value. With RAM_DOUT_REG_EN defined, the first test's response arrives at N+3.
